// File: rtl/hazard_scoreboard.sv
// RAW hazard scoreboard: one countdown per architectural register. A source that
// is still counting down stalls ID; a squashed EX instruction has its entry rolled back.
module hazard_cnt_cell #(
  parameter int CW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          hold,
  input  logic          setEn,
  input  logic [CW-1:0] setVal,
  input  logic          restoreEn,
  input  logic [CW-1:0] restoreVal,
  output logic [CW-1:0] cnt,
  output logic [CW-1:0] cntDec
);
  logic [CW-1:0] restoreDec;

  assign cntDec     = (cnt == '0) ? '0 : cnt - CW'(1);
  assign restoreDec = (restoreVal == '0) ? '0 : restoreVal - CW'(1);

  // A rollback under hold takes the saved value as is, because frozen cycles do not age entries.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)         cnt <= '0;
    else if (restoreEn) cnt <= hold ? restoreVal : restoreDec;
    else if (!hold)     cnt <= (setEn && setVal > cntDec) ? setVal : cntDec;
endmodule

module hazard_scoreboard #(
  parameter int REG_AW  = 3,
  parameter int NUM_SRC = 2,
  parameter int FWD_EN  = 1,
  parameter int ALU_LAT = 0,
  parameter int LD_LAT  = 1,
  parameter int WB_LAT  = 3,
  parameter int SCNT_W  = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      id_valid,
  input  logic [NUM_SRC*REG_AW-1:0] id_src_addr,
  input  logic [NUM_SRC-1:0]        id_src_en,
  input  logic [REG_AW-1:0]         id_dst_addr,
  input  logic                      id_dst_we,
  input  logic                      id_is_load,
  input  logic                      hold,
  input  logic                      ex_flush,
  input  logic                      clr_stats,
  output logic                      stall,
  output logic                      pc_we,
  output logic                      ifid_we,
  output logic                      idex_bubble,
  output logic [SCNT_W-1:0]         stall_cnt
);
  localparam int NREG = 1 << REG_AW;
  localparam int CW   = (WB_LAT < 1) ? 1 : $clog2(WB_LAT + 1);
  localparam logic [CW-1:0] ALU_L = CW'(ALU_LAT);
  localparam logic [CW-1:0] LD_L  = CW'(LD_LAT);
  localparam logic [CW-1:0] WB_L  = CW'(WB_LAT);

  logic [NREG-1:0][CW-1:0] cnt, cntDec;
  logic [CW-1:0]           issueLat, lastPrev;
  logic [REG_AW-1:0]       lastReg;
  logic                    srcHit, issue, lastValid;

  // A register read on several ports simply sets the same hit twice.
  always_comb begin
    srcHit = 1'b0;
    for (int k = 0; k < NUM_SRC; k++)
      if (id_src_en[k] && cnt[id_src_addr[k*REG_AW +: REG_AW]] != '0) srcHit = 1'b1;
  end

  assign stall       = id_valid & srcHit;
  assign issue       = id_valid & ~stall & ~hold & ~ex_flush;
  assign issueLat    = (FWD_EN != 0) ? (id_is_load ? LD_L : ALU_L) : WB_L;
  assign pc_we       = ~stall & ~hold;
  assign ifid_we     = ~stall & ~hold;
  assign idex_bubble = (stall | ex_flush) & ~hold;

  for (genvar r = 0; r < NREG; r++) begin : gCell
    hazard_cnt_cell #(.CW(CW)) uCell (
      .clk        (clk),
      .rst_n      (rst_n),
      .hold       (hold),
      .setEn      (issue & id_dst_we & (issueLat != '0) & (id_dst_addr == REG_AW'(r))),
      .setVal     (issueLat),
      .restoreEn  (ex_flush & lastValid & (lastReg == REG_AW'(r))),
      .restoreVal (lastPrev),
      .cnt        (cnt[r]),
      .cntDec     (cntDec[r])
    );
  end

  // Remember the pre-issue entry of the instruction entering EX so a flush can undo it.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      lastValid <= 1'b0;
      lastReg   <= '0;
      lastPrev  <= '0;
    end else if (ex_flush) begin
      lastValid <= 1'b0;
    end else if (!hold) begin
      lastValid <= issue;
      if (issue) begin
        lastReg  <= id_dst_addr;
        lastPrev <= cntDec[id_dst_addr];
      end
    end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)                                     stall_cnt <= '0;
    else if (clr_stats)                             stall_cnt <= '0;
    else if (stall && !hold && stall_cnt != '1)     stall_cnt <= stall_cnt + SCNT_W'(1);
endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameter REG_AW, default 3: register address width; the register file has 2**REG_AW entries.
REQ-002 Parameter NUM_SRC, default 2: number of source-operand ports checked per ID instruction.
REQ-003 Parameter FWD_EN, default 1: 1 = forwarding present, 0 = no forwarding (wait for writeback).
REQ-004 Parameter ALU_LAT, default 0; LD_LAT, default 1; WB_LAT, default 3: producer-to-consumer stall distances in cycles.
REQ-005 Parameter SCNT_W, default 16: width of the stall statistics counter.
REQ-006 clk  in  1  single clock; all state updates on its rising edge.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 id_valid  in  1  the ID-stage instruction is real (not a bubble).
REQ-009 id_src_addr  in  NUM_SRC*REG_AW  source register addresses; port k occupies bits [k*REG_AW +: REG_AW].
REQ-010 id_src_en  in  NUM_SRC  per-port flag: this source is actually read.
REQ-011 id_dst_addr  in  REG_AW  destination register of the ID instruction.
REQ-012 id_dst_we  in  1  the ID instruction writes id_dst_addr.
REQ-013 id_is_load  in  1  the ID instruction is a memory load.
REQ-014 hold  in  1  global pipeline freeze (memory wait); the scoreboard does not advance.
REQ-015 ex_flush  in  1  the instruction now in EX and the ID instruction are squashed.
REQ-016 clr_stats  in  1  synchronous clear of stall_cnt.
REQ-017 stall  out  1  RAW hazard detected on the ID instruction.
REQ-018 pc_we  out  1  PC write enable, equal to ~stall & ~hold.
REQ-019 ifid_we  out  1  IF/ID register write enable, equal to ~stall & ~hold.
REQ-020 idex_bubble  out  1  insert a NOP into ID/EX, equal to (stall | ex_flush) & ~hold.
REQ-021 stall_cnt  out  SCNT_W  saturating count of cycles with stall=1 and hold=0.

Function
REQ-022 One down-counter cnt[r] per register, width clog2(WB_LAT+1), holds the cycles until r can be consumed in ID.
REQ-023 stall is combinational: 1 iff id_valid and some port k has id_src_en[k]=1 and cnt[id_src_addr[k]] != 0.
REQ-024 An issue occurs in a cycle iff id_valid & ~stall & ~hold & ~ex_flush.
REQ-025 Issue latency L: FWD_EN=1 gives L=LD_LAT for loads and L=ALU_LAT otherwise; FWD_EN=0 gives L=WB_LAT for every writer.
REQ-026 In each cycle with hold=0, every nonzero cnt decrements by 1, saturating at 0.
REQ-027 On an issue with id_dst_we=1 and L>0, cnt[id_dst_addr] takes max(decremented value, L) (WAW safe).
REQ-028 On hold=1, all cnt values are unchanged and no issue occurs; stall is still evaluated.
REQ-029 Per issue, the block records last_valid, last_reg and last_prev (the decremented cnt[last_reg] value before the issue overwrote it).
REQ-030 In a cycle with hold=0 and no issue, last_valid is cleared.
REQ-031 On ex_flush=1 with last_valid=1, cnt[last_reg] takes last_prev decremented (saturating at 0); other registers decrement normally.
REQ-032 ex_flush acts even when hold=1; in that case only last_reg is restored (to last_prev undecremented), the other counters stay frozen, and last_valid clears.
REQ-033 With ALU_LAT=0, ALU writers create no entry, so back-to-back dependent ALU instructions never stall.
REQ-034 When the same register is read on two ports, it is checked once; the result is identical.
REQ-035 stall_cnt increments when stall=1 and hold=0, saturates at all-ones, and clears on clr_stats (clear has priority).

Reset
REQ-036 While rst_n=0: all cnt=0, last_valid=0, stall_cnt=0.
REQ-037 After reset: stall=0, pc_we=1, ifid_we=1, and idex_bubble=0 (with hold=0, ex_flush=0).
REQ-038 Reset asserted mid-stall cancels the stall in the same cycle, asynchronously.

Verification
REQ-039 Defaults, FWD_EN=1: load r3, then ADD reading r3 next cycle -> exactly 1 stall cycle, idex_bubble=1 once, stall_cnt=1.
REQ-040 FWD_EN=0, WB_LAT=3: ADD r2, then dependent ADD reading r2 -> 3 stall cycles; independent instruction reading r5 -> 0 stalls.
REQ-041 Load r4, then hold=1 for 4 cycles, then release -> cnt[r4] frozen at 1 during hold; 1 stall after release; stall_cnt counts only the non-hold stall cycle.
REQ-042 Load r1 issues; next cycle ex_flush=1 with a dependent instruction in ID -> cnt[r1]=0 afterwards; the refetched consumer does not stall.
REQ-043 WAW, FWD_EN=0: write r6 (cnt 3); next cycle an ALU instruction writes r6 -> cnt[r6] becomes max(2,3)=3.
REQ-044 rst_n pulsed low during a 3-cycle stall -> stall drops immediately, stall_cnt=0, and the next instruction issues with no stall.
